// File: rtl/count_decoder_pkg.sv
// Shared types and constants for the counter-observation decoder.
// Optional statistics outputs are enabled with the macro COUNT_DECODER_STATS_EN.
package count_decoder_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_RUN_W = 8;
    localparam int STAT_W        = 8;

    // Decoded relationship between two consecutive counter observations.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_HOLD = 3'd1,
        OP_UP   = 3'd2,
        OP_DOWN = 3'd3,
        OP_LOAD = 3'd4
    } op_e;

    // Direction tracker: S_INIT means no previous observation exists yet.
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_NODIR = 2'd1,
        S_UP    = 2'd2,
        S_DOWN  = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr has priority; clr together with inc restarts the count at 1.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count register: restart on clr, otherwise step until the ceiling.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= inc ? ONE : '0;
        end else if (inc && (value != MAX_VAL)) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/count_decoder.sv
// Observes a counter's value and flags, decodes the step taken between
// consecutive samples, tracks direction, and reports wraps, reversals and
// flag inconsistencies one cycle after each sample.
// Define COUNT_DECODER_STATS_EN to add saturating event counters.
module count_decoder
    import count_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int RUN_W = DEFAULT_RUN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             max_in,
    input  logic             zero_in,
    output logic             op_valid,
    output op_e              op,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             dir_change,
    output logic             flag_err,
    output logic [RUN_W-1:0] run_len
`ifdef COUNT_DECODER_STATS_EN
    ,
    output logic [STAT_W-1:0] wrap_up_cnt,
    output logic [STAT_W-1:0] wrap_dn_cnt,
    output logic [STAT_W-1:0] err_cnt
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_plus;
    logic [WIDTH-1:0] prev_minus;

    op_e  op_d;
    logic wrap_up_d;
    logic wrap_dn_d;
    logic dir_change_d;
    logic flag_err_d;
    logic run_inc;
    logic run_clr;

    // Neighbours of the previous value, wrapping modulo 2^WIDTH.
    assign prev_plus  = prev_q + ONE;
    assign prev_minus = prev_q - ONE;

    // Decode the sample, pick the next direction state and the run-length action.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        op_d         = OP_NONE;
        state_d      = state_q;
        wrap_up_d    = 1'b0;
        wrap_dn_d    = 1'b0;
        dir_change_d = 1'b0;
        flag_err_d   = 1'b0;
        run_inc      = 1'b0;
        run_clr      = 1'b0;

        if (sample_en) begin
            flag_err_d = (max_in != (cnt_in == ALL_ONES)) ||
                         (zero_in != (cnt_in == '0));

            if (state_q == S_INIT) begin
                op_d = OP_LOAD;
            end else if (cnt_in == prev_q) begin
                op_d = OP_HOLD;
            end else if (cnt_in == prev_plus) begin
                op_d = OP_UP;
            end else if (cnt_in == prev_minus) begin
                op_d = OP_DOWN;
            end else begin
                op_d = OP_LOAD;
            end

            unique case (op_d)
                OP_UP: begin
                    wrap_up_d    = (prev_q == ALL_ONES);
                    dir_change_d = (state_q == S_DOWN);
                    run_inc      = 1'b1;
                    run_clr      = (state_q != S_UP);
                    state_d      = S_UP;
                end
                OP_DOWN: begin
                    wrap_dn_d    = (prev_q == '0);
                    dir_change_d = (state_q == S_UP);
                    run_inc      = 1'b1;
                    run_clr      = (state_q != S_DOWN);
                    state_d      = S_DOWN;
                end
                OP_LOAD: begin
                    run_clr = 1'b1;
                    state_d = S_NODIR;
                end
                default: begin
                    // OP_HOLD: direction and run length are kept, so a later
                    // opposite step still counts as a reversal.
                end
            endcase
        end
    end

    // Direction state register.
    // NOTE: reset clears control state only; there are no memories here that would need it skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Previous observation, refreshed on every accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (sample_en) begin
            prev_q <= cnt_in;
        end
    end

    // Registered decode outputs; pulses and op_valid drop when no sample is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid   <= 1'b0;
            op         <= OP_NONE;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
            dir_change <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            op_valid   <= sample_en;
            op         <= op_d;
            wrap_up    <= wrap_up_d;
            wrap_dn    <= wrap_dn_d;
            dir_change <= dir_change_d;
            flag_err   <= flag_err_d;
        end
    end

    sat_counter #(
        .WIDTH (RUN_W)
    ) u_run_len (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (run_inc),
        .clr   (run_clr),
        .value (run_len)
    );

`ifdef COUNT_DECODER_STATS_EN
    sat_counter #(
        .WIDTH (STAT_W)
    ) u_wrap_up_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wrap_up_d),
        .clr   (1'b0),
        .value (wrap_up_cnt)
    );

    sat_counter #(
        .WIDTH (STAT_W)
    ) u_wrap_dn_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wrap_dn_d),
        .clr   (1'b0),
        .value (wrap_dn_cnt)
    );

    sat_counter #(
        .WIDTH (STAT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flag_err_d),
        .clr   (1'b0),
        .value (err_cnt)
    );
`endif

endmodule

// File: tb/tb_count_decoder.sv
// Directed bench for count_decoder (WIDTH=4, RUN_W=8) with a scoreboard queue.
module tb_count_decoder;
    import count_decoder_pkg::*;

    localparam int WIDTH = 4;
    localparam int RUN_W = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             sample_en = 1'b0;
    logic [WIDTH-1:0] cnt_in    = '0;
    logic             max_in    = 1'b0;
    logic             zero_in   = 1'b0;
    logic             op_valid;
    op_e              op;
    logic             wrap_up;
    logic             wrap_dn;
    logic             dir_change;
    logic             flag_err;
    logic [RUN_W-1:0] run_len;
`ifdef COUNT_DECODER_STATS_EN
    logic [7:0] wrap_up_cnt;
    logic [7:0] wrap_dn_cnt;
    logic [7:0] err_cnt;
`endif

    typedef struct {
        op_e  op;
        logic wu;
        logic wd;
        logic dc;
        logic fe;
        int   rl;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   exp_wu_cnt  = 0;
    int   exp_wd_cnt  = 0;
    int   exp_err_cnt = 0;

    count_decoder #(
        .WIDTH (WIDTH),
        .RUN_W (RUN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .cnt_in     (cnt_in),
        .max_in     (max_in),
        .zero_in    (zero_in),
        .op_valid   (op_valid),
        .op         (op),
        .wrap_up    (wrap_up),
        .wrap_dn    (wrap_dn),
        .dir_change (dir_change),
        .flag_err   (flag_err),
        .run_len    (run_len)
`ifdef COUNT_DECODER_STATS_EN
        ,
        .wrap_up_cnt (wrap_up_cnt),
        .wrap_dn_cnt (wrap_dn_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s cnt_in=%0d observed=%0d expected=%0d", tag, cnt_in, act, exp);
        end
    endtask

    task automatic check_stats();
`ifdef COUNT_DECODER_STATS_EN
        check("wrap_up_cnt", wrap_up_cnt, exp_wu_cnt);
        check("wrap_dn_cnt", wrap_dn_cnt, exp_wd_cnt);
        check("err_cnt",     err_cnt,     exp_err_cnt);
`endif
    endtask

    // Drive one sample, push its expectation, compare after the capturing edge.
    task automatic send(input logic [WIDTH-1:0] c, input logic mx, input logic zr,
                        input op_e eop, input logic ewu, input logic ewd,
                        input logic edc, input logic efe, input int erl);
        exp_t e;
        exp_t got;
        @(negedge clk);
        sample_en = 1'b1;
        cnt_in    = c;
        max_in    = mx;
        zero_in   = zr;
        e.op = eop; e.wu = ewu; e.wd = ewd; e.dc = edc; e.fe = efe; e.rl = erl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            if (got.wu && exp_wu_cnt < 255) exp_wu_cnt++;
            if (got.wd && exp_wd_cnt < 255) exp_wd_cnt++;
            if (got.fe && exp_err_cnt < 255) exp_err_cnt++;
            check("op_valid",   op_valid,   1);
            check("op",         op,         got.op);
            check("wrap_up",    wrap_up,    got.wu);
            check("wrap_dn",    wrap_dn,    got.wd);
            check("dir_change", dir_change, got.dc);
            check("flag_err",   flag_err,   got.fe);
            check("run_len",    run_len,    got.rl);
            check_stats();
        end
    endtask

    // Sample with self-consistent flags.
    task automatic send_ok(input logic [WIDTH-1:0] c, input op_e eop, input logic ewu,
                           input logic ewd, input logic edc, input int erl);
        send(c, (c == 4'd15), (c == 4'd0), eop, ewu, ewd, edc, 1'b0, erl);
    endtask

    // A cycle with no sample: nothing may move.
    task automatic idle(input int erl);
        @(negedge clk);
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        check("idle_op_valid",   op_valid,   0);
        check("idle_wrap_up",    wrap_up,    0);
        check("idle_wrap_dn",    wrap_dn,    0);
        check("idle_dir_change", dir_change, 0);
        check("idle_flag_err",   flag_err,   0);
        check("idle_run_len",    run_len,    erl);
        check_stats();
    endtask

    // Asynchronous reset a few ns after an edge; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_wu_cnt  = 0;
        exp_wd_cnt  = 0;
        exp_err_cnt = 0;
        check("rst_op_valid",   op_valid,   0);
        check("rst_op",         op,         OP_NONE);
        check("rst_wrap_up",    wrap_up,    0);
        check("rst_wrap_dn",    wrap_dn,    0);
        check("rst_dir_change", dir_change, 0);
        check("rst_flag_err",   flag_err,   0);
        check("rst_run_len",    run_len,    0);
        check_stats();
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rl;
        logic [WIDTH-1:0] c;

        // Power-on reset state.
        #12;
        check("por_op_valid", op_valid, 0);
        check("por_op",       op,       OP_NONE);
        check("por_run_len",  run_len,  0);
        check("por_pulses",   {wrap_up, wrap_dn, dir_change, flag_err}, 0);
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;

        // First sample loads, then two up-steps.
        send_ok(4'd3,  OP_LOAD, 0, 0, 0, 0);
        send_ok(4'd4,  OP_UP,   0, 0, 0, 1);
        send_ok(4'd5,  OP_UP,   0, 0, 0, 2);

        // Up-run across the all-ones boundary.
        send_ok(4'd13, OP_LOAD, 0, 0, 0, 0);
        send_ok(4'd14, OP_UP,   0, 0, 0, 1);
        send_ok(4'd15, OP_UP,   0, 0, 0, 2);
        send_ok(4'd0,  OP_UP,   1, 0, 0, 3);

        // Reversal with a hold in between.
        send_ok(4'd5,  OP_LOAD, 0, 0, 0, 0);
        send_ok(4'd6,  OP_UP,   0, 0, 0, 1);
        send_ok(4'd6,  OP_HOLD, 0, 0, 0, 1);
        send_ok(4'd5,  OP_DOWN, 0, 0, 1, 1);

        // Loads and a flag disagreement; the following down-step starts from no direction.
        send(4'd0,  1'b0, 1'b1, OP_LOAD, 0, 0, 0, 0, 0);
        send_ok(4'd9,  OP_LOAD, 0, 0, 0, 0);
        send(4'd15, 1'b0, 1'b0, OP_LOAD, 0, 0, 0, 1, 0);
        send_ok(4'd14, OP_DOWN, 0, 0, 0, 1);
        idle(1);

        // Down-run across zero, then reset mid-stream.
        send_ok(4'd2,  OP_LOAD, 0, 0, 0, 0);
        send_ok(4'd1,  OP_DOWN, 0, 0, 0, 1);
        send_ok(4'd0,  OP_DOWN, 0, 0, 0, 2);
        send_ok(4'd15, OP_DOWN, 0, 1, 0, 3);
        async_reset();
        send_ok(4'd7,  OP_LOAD, 0, 0, 0, 0);

        // Long up-run: run_len saturates; idle gaps leave everything unchanged.
        for (int i = 1; i <= 260; i++) begin
            c  = 4'(7 + i);
            rl = (i < 255) ? i : 255;
            send_ok(c, OP_UP, (c == 4'd0), 0, 0, rl);
            if (i % 64 == 0) idle(rl);
        end

        // After reset a sample equal to the cleared prev value is still a load.
        async_reset();
        send_ok(4'd0, OP_LOAD, 0, 0, 0, 0);
        send_ok(4'd15, OP_DOWN, 0, 1, 0, 1);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
